// File: rtl/afifo_pop_unpacker_pkg.sv
// Shared helpers for the asymmetric BRAM FIFO packer/unpacker pair:
// width-ratio legality, beat-to-slice mapping and the word-buffer state type.
package afifo_pop_unpacker_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    // FIFO port must be 9/18/36 bits and split into 1, 2 or 4 equal beats.
    function automatic bit ratio_legal(input int fifo_w, input int out_w);
        int ratio;
        if (out_w <= 0) return 1'b0;
        if (!(fifo_w == 9 || fifo_w == 18 || fifo_w == 36)) return 1'b0;
        if ((fifo_w % out_w) != 0) return 1'b0;
        ratio = fifo_w / out_w;
        return (ratio == 1) || (ratio == 2) || (ratio == 4);
    endfunction

    function automatic int slice_index(input int beat, input int ratio, input bit lsb_first);
        return lsb_first ? beat : (ratio - 1 - beat);
    endfunction

endpackage

// File: rtl/afifo_word_skid2.sv
// Two-entry word buffer (head + spare) with occupancy; a vacating head is
// refilled from spare, or straight from the write port when spare is empty.
module afifo_word_skid2
    import afifo_pop_unpacker_pkg::*;
#(
    parameter int WIDTH = 36
) (
    input  logic             clock0,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       occupied
);

    skid_state_t      state_reg, state_next;
    logic [WIDTH-1:0] head_reg, spare_reg;
    logic             head_write, spare_write, head_from_spare;

    always_ff @(posedge clock0) begin
        if (reset || flush) state_reg <= SKID_EMPTY;
        else                state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SKID_EMPTY: if (wr_en) state_next = SKID_ONE;
            SKID_ONE: begin
                if (wr_en && !rd_en)      state_next = SKID_TWO;
                else if (!wr_en && rd_en) state_next = SKID_EMPTY;
            end
            SKID_TWO:   if (rd_en && !wr_en) state_next = SKID_ONE;
            default:    state_next = SKID_EMPTY;
        endcase
    end

    assign head_write      = wr_en && ((state_reg == SKID_EMPTY) || (state_reg == SKID_ONE && rd_en));
    assign spare_write     = wr_en && !head_write;
    assign head_from_spare = rd_en && (state_reg == SKID_TWO);

    // Data is only zeroed by reset; a flush just drops occupancy.
    always_ff @(posedge clock0) begin
        if (reset) begin
            head_reg  <= '0;
            spare_reg <= '0;
        end else if (!flush) begin
            if (head_from_spare) head_reg <= spare_reg;
            else if (head_write) head_reg <= wr_data;
            if (spare_write)     spare_reg <= wr_data;
        end
    end

    assign head_data  = head_reg;
    assign head_valid = (state_reg != SKID_EMPTY);
    assign occupied   = state_reg;

endmodule

// File: rtl/afifo_pop_unpacker.sv
// Read-side controller for the asymmetric BRAM FIFO: issues POP against buffer
// credit, captures DOUT one cycle later and unpacks each word into narrow beats.
module afifo_pop_unpacker
    import afifo_pop_unpacker_pkg::*;
#(
    parameter int FIFO_WIDTH = 36,
    parameter int OUT_WIDTH  = 9,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clock0,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic                  fifo_underrun,
    output logic                  fifo_pop,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [31:0]           words_popped,
    output logic                  underrun_seen
);

    localparam int RATIO  = FIFO_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    generate
        if (!ratio_legal(FIFO_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
            $error("afifo_pop_unpacker: FIFO_WIDTH/OUT_WIDTH must be 1, 2 or 4 with FIFO_WIDTH in {9,18,36}");
        end
    endgenerate

    logic                  inflight_reg;
    logic [BEAT_W-1:0]     beat_reg;
    logic [31:0]           words_popped_reg;
    logic                  underrun_seen_reg;
    logic [FIFO_WIDTH-1:0] head_data;
    logic                  head_valid;
    logic [1:0]            occupied;
    logic                  accept, beat_last, last_accept;
    logic [2:0]            credit_used, credit_limit;
    logic [BEAT_W-1:0]     slice_sel;
    logic [OUT_WIDTH-1:0]  slice_masked [RATIO];

    afifo_word_skid2 #(.WIDTH(FIFO_WIDTH)) u_skid (
        .clock0     (clock0),
        .reset      (reset),
        .flush      (flush),
        .wr_en      (inflight_reg),
        .wr_data    (fifo_dout),
        .rd_en      (last_accept),
        .head_data  (head_data),
        .head_valid (head_valid),
        .occupied   (occupied)
    );

    assign accept      = head_valid && out_ready;
    assign beat_last   = (beat_reg == BEAT_W'(RATIO - 1));
    assign last_accept = accept && beat_last;

    // A head vacating this cycle frees one slot, which is what lets RATIO=1 pop every cycle.
    assign credit_used  = {1'b0, occupied} + {2'b00, inflight_reg};
    assign credit_limit = last_accept ? 3'd3 : 3'd2;
    assign fifo_pop     = !fifo_empty && !reset && !flush && (credit_used < credit_limit);

    always_ff @(posedge clock0) begin
        if (reset) begin
            inflight_reg      <= 1'b0;
            beat_reg          <= '0;
            words_popped_reg  <= '0;
            underrun_seen_reg <= 1'b0;
        end else begin
            if (fifo_pop)      words_popped_reg  <= words_popped_reg + 32'd1;
            if (fifo_underrun) underrun_seen_reg <= 1'b1;
            if (flush) begin
                inflight_reg <= 1'b0;
                beat_reg     <= '0;
            end else begin
                inflight_reg <= fifo_pop;
                if (accept) beat_reg <= beat_last ? '0 : beat_reg + BEAT_W'(1);
            end
        end
    end

    assign slice_sel = BEAT_W'(slice_index(int'(beat_reg), RATIO, LSB_FIRST));

    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
        assign slice_masked[gi] = (slice_sel == BEAT_W'(gi)) ?
                                  head_data[gi*OUT_WIDTH +: OUT_WIDTH] : '0;
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < RATIO; i++) out_data = out_data | slice_masked[i];
    end

    assign out_valid     = head_valid;
    assign out_last      = beat_last;
    assign words_popped  = words_popped_reg;
    assign underrun_seen = underrun_seen_reg;

endmodule

// File: doc/afifo_pop_unpacker.md
# afifo_pop_unpacker

Single-clock read-side controller for the asymmetric BRAM36K async FIFO. Drives the FIFO's `POP` from `Empty`, captures `DOUT` under its one-cycle read latency, and unpacks each wide FIFO word into narrow beats on a valid/ready stream. It lives in the read clock domain, the mirror of a push-side packer, and lets fabric logic consume FIFO contents without hand-timing `POP`.

## Interface
Parameters:
- `FIFO_WIDTH`, 36: width of FIFO `DOUT`; must be one of 9, 18, 36.
- `OUT_WIDTH`, 9: beat width. `RATIO = FIFO_WIDTH/OUT_WIDTH` must be 1, 2 or 4; any other value is an elaboration error.
- `LSB_FIRST`, 1: 1 emits `word[OUT_WIDTH-1:0]` first; 0 emits the MS slice first.

Ports:
- `clock0`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous clear of buffered data; same effect as `reset` except counters are kept.
- `fifo_empty`  in  1  FIFO `Empty`.
- `fifo_underrun`  in  1  FIFO `Underrun_Error`.
- `fifo_pop`  out  1  FIFO `POP`.
- `fifo_dout`  in  FIFO_WIDTH  FIFO `DOUT`, valid exactly 1 cycle after the `fifo_pop` cycle.
- `out_data`  out  OUT_WIDTH  current beat.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.
- `out_last`  out  1  beat is the final slice of its word.
- `words_popped`  out  32  count of pops issued, wraps modulo 2^32.
- `underrun_seen`  out  1  sticky copy of `fifo_underrun`.

## Operation
- Two-entry word buffer (head, spare) plus a 1-bit `inflight` flag for a pop whose data returns next cycle.
- Credit rule: `fifo_pop = ~fifo_empty & ~reset & ~flush & (occupied + inflight < 2)`, where `occupied` counts entries already in the buffer, or `(occupied + inflight < 3)` when the head's last beat is accepted in the same cycle. This sustains 1 word/cycle at `RATIO=1`.
- Return cycle (`inflight` was 1): `fifo_dout` is written into head if head is empty (or vacating this cycle), else into spare. The write is unconditional; `out_ready` cannot drop returned data.
- Beat counter `beat` (0..RATIO-1) indexes head: slice `beat` when `LSB_FIRST=1`, slice `RATIO-1-beat` otherwise.
- `out_valid = head occupied`; `out_last = (beat == RATIO-1)`.
- On accept: if not last, `beat++`; if last, `beat <= 0`, spare moves to head (or head empties).
- States: EMPTY (occupied=0), ONE, TWO. Transitions follow the +return/−last-accept deltas, with simultaneous events netting out.
- `fifo_pop` is never asserted while `fifo_empty=1`. `underrun_seen` latches any `fifo_underrun` pulse and clears only on `reset`.
- `flush`/`reset` mid-operation: buffer, `beat` and `inflight` are cleared. A word returning on the following cycle is discarded, and `fifo_pop` is held low in the flush cycle.

## Timing
- Reset values: `fifo_pop=0`, `out_valid=0`, `out_last=0` (RATIO>1), `out_data=0`, `words_popped=0`, `underrun_seen=0`.
- Latency: `fifo_pop` at cycle N, then data in head at N+1, then `out_valid` visible at N+1 edge (first beat out 2 edges after the `fifo_pop` cycle's first edge, i.e. registered).
- `out_data`/`out_valid`/`out_last` are register outputs. `fifo_pop` is combinational from registered state and `fifo_empty`.
- Valid/ready: once `out_valid` is high, `out_data` and `out_last` hold stable until accepted.

## Structure
- A shared package holds the `RATIO` legality check function and the beat-slice index function (`LSB_FIRST` mapping), reused by the push-side packer.
- One sub-module: `afifo_word_skid2`, the 2-entry word buffer with occupancy. The unpack and beat logic sits in the top.

## Test plan
- 36→9, LSB_FIRST=1, `fifo_empty=0` constantly, `out_ready=1`: words {9'h004,9'h003,9'h002,9'h001}, {…8,7,6,5} → beats 1..8 consecutive, `out_last` on 4 and 8, `fifo_pop` one cycle in four at steady state.
- 9→9 (RATIO=1), continuous: `fifo_pop` high every cycle, one beat per cycle, `words_popped` matches beats, no data lost.
- Backpressure: `out_ready` toggled 1-of-3 with `fifo_empty=0` → never more than 2 words buffered plus 1 inflight, no drop or duplicate, `out_data` stable while stalled.
- Empty boundary: `fifo_empty` rises immediately after one pop → exactly 1 word emitted, `fifo_pop` stays 0 while empty.
- `flush` asserted with a pop inflight and 2 words buffered → `out_valid=0` next cycle, returning word discarded, `words_popped` unchanged; the next word after flush emits correctly.
- 18→9, LSB_FIRST=0, word 18'h3_0201 → beats 9'h181 then 9'h001; an `fifo_underrun` pulse sets `underrun_seen`, which stays 1 until `reset`.
